// File: rtl/pipe_stage.sv
// pipe_stage: valid/ready inter-stage register with synchronous flush and NOP-masked control field.
// Define PIPE_STAGE_SKID_EN to build the 2-entry variant with a skid register and registered in_ready.
module pipe_stage #(
    parameter int CTRL_W = 11,
    parameter int DATA_W = 180
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              m_valid;
    logic [CTRL_W-1:0] m_ctrl;
    logic [DATA_W-1:0] m_data;
    logic [1:0]        occ_q;

    logic in_fire;
    logic out_fire;
    logic m_free;

    assign out_valid = m_valid;
    assign out_ctrl  = m_ctrl & {CTRL_W{m_valid}};
    assign out_data  = m_data;
    assign occupancy = occ_q;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = m_valid && out_ready;
    assign m_free   = !m_valid || out_fire;

`ifdef PIPE_STAGE_SKID_EN
    logic              s_valid;
    logic [CTRL_W-1:0] s_ctrl;
    logic [DATA_W-1:0] s_data;
    logic              m_valid_n;
    logic              s_valid_n;

    // S is only ever valid behind a valid M, so !s_valid also means "not full".
    assign in_ready = !s_valid;

    always_comb begin
        m_valid_n = m_valid;
        s_valid_n = s_valid;
        if (m_free) begin
            if (s_valid) begin
                m_valid_n = 1'b1;
                s_valid_n = 1'b0;
            end else begin
                m_valid_n = in_fire;
            end
        end else if (in_fire) begin
            s_valid_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            m_valid <= 1'b0;
            m_ctrl  <= '0;
            m_data  <= '0;
            s_valid <= 1'b0;
            s_ctrl  <= '0;
            s_data  <= '0;
            occ_q   <= '0;
        end else begin
            m_valid <= m_valid_n;
            s_valid <= s_valid_n;
            occ_q   <= {1'b0, m_valid_n} + {1'b0, s_valid_n};
            // in_ready is low whenever S is valid, so S and the input never compete for M.
            if (m_free && s_valid) begin
                m_ctrl <= s_ctrl;
                m_data <= s_data;
            end else if (m_free && in_fire) begin
                m_ctrl <= in_ctrl;
                m_data <= in_data;
            end
            if (!m_free && in_fire) begin
                s_ctrl <= in_ctrl;
                s_data <= in_data;
            end
        end
    end
`else
    logic m_valid_n;

    assign in_ready = m_free;

    always_comb begin
        m_valid_n = m_valid;
        if (m_free) begin
            m_valid_n = in_fire;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            m_valid <= 1'b0;
            m_ctrl  <= '0;
            m_data  <= '0;
            occ_q   <= '0;
        end else begin
            m_valid <= m_valid_n;
            occ_q   <= {1'b0, m_valid_n};
            if (m_free && in_fire) begin
                m_ctrl <= in_ctrl;
                m_data <= in_data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage; compares against a queue model of the stage.
// Define PIPE_STAGE_SKID_EN here as for the RTL to check the skid variant.
module tb_pipe_stage;
    localparam int CTRL_W = 11;
    localparam int DATA_W = 180;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic              clk = 1'b0;
    logic              reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [CTRL_W-1:0] in_ctrl, out_ctrl;
    logic [DATA_W-1:0] in_data, out_data;
    logic [1:0]        occupancy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t              q[$];
    logic [DATA_W-1:0] last_d = '0;
    logic              acc = 1'b0;

    always #5 clk = ~clk;

    pipe_stage #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy)
    );

    function automatic logic mdl_in_ready();
        if (CAP == 2) return q.size() < 2;
        return (q.size() == 0) || out_ready;
    endfunction

    function automatic logic [CTRL_W-1:0] mdl_ctrl();
        if (q.size() > 0) return q[0].c;
        return '0;
    endfunction

    // Advance one clock: decide transfers from the model, then update the model at the edge.
    task automatic clk_step();
        logic inf, outf;
        #1;
        inf  = in_valid && mdl_in_ready();
        outf = (q.size() > 0) && out_ready;
        @(posedge clk);
        if (reset || flush) begin
            q.delete();
            last_d = '0;
        end else begin
            if (outf) void'(q.pop_front());
            if (inf) q.push_back(ent_t'{c: in_ctrl, d: in_data});
        end
        if (q.size() > 0) last_d = q[0].d;
        acc = inf && !reset && !flush;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_ctrl = '1; in_data = '1; out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            clk_step();
            checks++;
            if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0 || occupancy !== 2'd0) begin
                errors++;
                $display("FAIL reset_state cyc=%0d got v=%b c=%h d=%h occ=%0d exp v=0 c=0 d=0 occ=0",
                         i, out_valid, out_ctrl, out_data, occupancy);
            end
        end
        reset = 1'b0; in_valid = 1'b0;
        clk_step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_ctrl = 11'h7FF; in_data = DATA_W'(i);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_in_ready i=%0d got=%b exp=1", i, in_ready);
            end
            clk_step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== DATA_W'(i) || out_ctrl !== 11'h7FF || occupancy !== 2'd1) begin
                errors++;
                $display("FAIL stream_out i=%0d got v=%b c=%h d=%0d occ=%0d exp v=1 c=7ff d=%0d occ=1",
                         i, out_valid, out_ctrl, out_data, occupancy, i);
            end
        end
        in_valid = 1'b0;
        clk_step();
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== DATA_W'(8) || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL stream_drain got v=%b c=%h d=%0d occ=%0d exp v=0 c=0 d=8 occ=0",
                     out_valid, out_ctrl, out_data, occupancy);
        end
    endtask

`ifdef PIPE_STAGE_SKID_EN
    task automatic test_skid();
        logic [DATA_W-1:0] exp_d[2];
        exp_d[0] = DATA_W'(32'hA);
        exp_d[1] = DATA_W'(32'hB);
        out_ready = 1'b0; in_ctrl = 11'h123;
        in_valid = 1'b1; in_data = exp_d[0];
        clk_step();
        in_data = exp_d[1];
        clk_step();
        in_valid = 1'b0;
        checks++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL skid_full got occ=%0d rdy=%b exp occ=2 rdy=0", occupancy, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            clk_step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d[i]) begin
                errors++;
                $display("FAIL skid_order i=%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, exp_d[i]);
            end
        end
        clk_step();
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL skid_empty got v=%b c=%h rdy=%b exp v=0 c=0 rdy=1", out_valid, out_ctrl, in_ready);
        end
    endtask
`else
    task automatic test_comb_ready();
        out_ready = 1'b0; in_ctrl = 11'h0F0;
        in_valid = 1'b1; in_data = DATA_W'(32'h21);
        clk_step();
        in_data = DATA_W'(32'h22);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL comb_ready_stall got=%b exp=0", in_ready);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL comb_ready_release got=%b exp=1", in_ready);
        end
        clk_step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== DATA_W'(32'h22) || occupancy !== 2'd1) begin
            errors++;
            $display("FAIL comb_ready_load got v=%b d=%h occ=%0d exp v=1 d=22 occ=1", out_valid, out_data, occupancy);
        end
        in_valid = 1'b0;
        clk_step();
    endtask
`endif

    task automatic test_flush();
        out_ready = 1'b0; in_ctrl = 11'h3C3;
        for (int i = 0; i < CAP; i++) begin
            in_valid = 1'b1; in_data = DATA_W'(32'h11 + i);
            clk_step();
        end
        in_valid = 1'b0;
        checks++;
        if (occupancy !== 2'(CAP)) begin
            errors++;
            $display("FAIL flush_fill got occ=%0d exp=%0d", occupancy, CAP);
        end
        flush = 1'b1; in_valid = 1'b1; in_data = DATA_W'(32'hC);
        clk_step();
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== '0 || out_ctrl !== '0) begin
            errors++;
            $display("FAIL flush_clear got v=%b occ=%0d d=%h c=%h exp v=0 occ=0 d=0 c=0",
                     out_valid, occupancy, out_data, out_ctrl);
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clk_step();
            checks++;
            if (out_valid !== 1'b0 || out_data === DATA_W'(32'hC)) begin
                errors++;
                $display("FAIL flush_discard i=%0d got v=%b d=%h exp v=0 d!=c", i, out_valid, out_data);
            end
        end
    endtask

    task automatic test_bubble();
        logic [2:0]        pat;
        logic [CTRL_W-1:0] exp_c;
        pat = 3'b101;
        out_ready = 1'b1; in_ctrl = 11'h155;
        for (int i = 0; i < 3; i++) begin
            in_valid = pat[2-i]; in_data = DATA_W'(32'h40 + i);
            clk_step();
            exp_c = pat[2-i] ? 11'h155 : 11'h000;
            checks++;
            if (out_valid !== pat[2-i] || out_ctrl !== exp_c) begin
                errors++;
                $display("FAIL bubble i=%0d got v=%b c=%h exp v=%b c=%h", i, out_valid, out_ctrl, pat[2-i], exp_c);
            end
        end
        in_valid = 1'b0;
        clk_step();
    endtask

    task automatic test_random();
        logic [191:0] r;
        for (int cyc = 0; cyc < 800; cyc++) begin
            reset = ($urandom_range(0, 99) < 2);
            flush = ($urandom_range(0, 99) < 5);
            if (!(in_valid && !acc)) begin
                r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                in_valid = ($urandom_range(0, 2) != 0);
                in_ctrl  = CTRL_W'($urandom);
                in_data  = r[DATA_W-1:0];
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (in_ready !== mdl_in_ready()) begin
                errors++;
                $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, mdl_in_ready());
            end
            clk_step();
            checks++;
            if (out_valid !== (q.size() > 0) || out_ctrl !== mdl_ctrl() ||
                out_data !== last_d || occupancy !== 2'(q.size())) begin
                errors++;
                $display("FAIL rnd_out cyc=%0d got v=%b c=%h occ=%0d d=%h exp v=%b c=%h occ=%0d d=%h",
                         cyc, out_valid, out_ctrl, occupancy, out_data,
                         q.size() > 0, mdl_ctrl(), q.size(), last_d);
            end
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        clk_step();
    endtask

    initial begin
        test_reset();
        test_streaming();
`ifdef PIPE_STAGE_SKID_EN
        test_skid();
`else
        test_comb_ready();
`endif
        test_flush();
        test_bubble();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage.md
# pipe_stage

Parametrised pipeline stage register with a valid/ready handshake, synchronous flush and bubble insertion. It replaces the fixed-width, always-enabled inter-stage registers between the fetch, decode, execute, memory and writeback stages. It carries a control field that is forced to zero (a NOP) whenever the stage holds no instruction, and an optional skid buffer that breaks the combinational ready path.

## Interface

Parameters:
- CTRL_W, 11: width of the control field (RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUControl, ALUSrc); masked to 0 on bubbles.
- DATA_W, 180: width of the data field (operands, PC, register indices, immediate, PC+4); not masked.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous flush; empties the stage at the next edge.
- in_valid  input  1  upstream holds a valid instruction.
- in_ready  output  1  stage accepts the input this cycle.
- in_ctrl  input  CTRL_W  upstream control field.
- in_data  input  DATA_W  upstream data field.
- out_valid  output  1  stage holds a valid instruction.
- out_ready  input  1  downstream accepts this cycle.
- out_ctrl  output  CTRL_W  control field; 0 whenever out_valid=0.
- out_data  output  DATA_W  data field.
- occupancy  output  2  number of held entries (0..2; max 1 without skid).

## Operation

- Input transfer: in_valid && in_ready at the edge. Output transfer: out_valid && out_ready at the edge.
- Main register M drives out_*. Skid register S exists only with the skid buffer enabled.
- M load: M is empty, or M fires on the output. M loads from S if S is valid, otherwise from the input if the input fires, otherwise it becomes empty.
- S load, skid only: the input fires while M is valid and does not fire. The entry goes to S.
- Order: strictly FIFO. An entry in S always leaves before any newer input.
- Bubble: out_ctrl = M.ctrl & {CTRL_W{out_valid}}. out_data holds the last loaded value when empty.
- Reset: M and S are invalid, and both ctrl and data are cleared to 0. After reset, out_valid=0, out_ctrl=0, out_data=0 and occupancy=0. in_ready=1 in the cycle after reset deasserts.
- Flush: M and S become invalid and their data is cleared to 0, as with reset.
  - Any input transfer in the flush cycle is discarded.
  - An output transfer in the flush cycle completes normally, because the consumer already sampled it.
- Reset has priority over flush, and flush has priority over all transfers.
- in_valid must stay high with stable ctrl/data until the transfer occurs. The stage never drops a held entry except on flush or reset.

## Timing

- Latency: 1 cycle. An input accepted at edge N appears on out_* after edge N.
- Throughput: 1 entry per cycle when out_ready=1 continuously.
- With skid: in_ready = !S.valid, taken directly from a register. There is no combinational in_ready path from out_ready.
  - in_ready drops 1 cycle after the first downstream stall that coincides with an input transfer.
  - in_ready recovers 1 cycle after S drains.
- Without skid: in_ready = !M.valid || out_ready, which is combinational from out_ready.
- occupancy is registered and updates at the same edge as the M and S valid bits.
- Simultaneous input and output transfer with S empty: M is replaced and occupancy is unchanged.

## Configuration

- PIPE_STAGE_SKID_EN defined: the 2-entry stage with skid register S is built and in_ready is registered.
  - Full condition: occupancy=2, in_ready=0.
- PIPE_STAGE_SKID_EN undefined: the 1-entry stage is built, S is absent, and in_ready is combinational.
  - occupancy takes only the values 0 and 1.
  - Functional sequence at out_* is identical for any stimulus the 1-entry stage accepts.

## Test plan

- Reset: assert reset for 2 cycles with in_valid=1 and in_ctrl=all ones. Required: out_valid=0, out_ctrl=0, out_data=0, occupancy=0 throughout. One cycle after release, in_ready=1.
- Streaming: with out_ready=1, drive 8 back-to-back entries with data 1..8 and ctrl=0x7FF. Required: out_data 1..8 on consecutive cycles, each 1 cycle after its input, with no gaps.
- Skid, PIPE_STAGE_SKID_EN set: hold out_ready=0 and drive data 0xA then 0xB.
  - Required: occupancy=2 and in_ready=0.
  - Then raise out_ready. Required: 0xA, then 0xB, then out_valid=0 with out_ctrl=0.
- Flush: with occupancy=2, assert flush alongside in_valid=1 and data 0xC. Required on the next cycle: out_valid=0, occupancy=0, out_data=0, and 0xC never appears at the output.
- Bubble: use in_valid pattern 1,0,1 with ctrl=0x155. Required: out_ctrl sequence 0x155, 0x000, 0x155 and out_valid sequence 1, 0, 1.
- Without the macro: hold out_ready=0 with M full. Required: in_ready=0. Raise out_ready in the same cycle. Required: in_ready=1 combinationally and a new entry loads at the edge.
